// File: rtl/data_mem_lsu.sv
`default_nettype none
// ============================================================================
// data_mem_lsu : byte-addressed data memory with RV32I load/store front end
// Rev 1.0 : initial release
// ============================================================================
module data_mem_lsu #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       rdata
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-3:0] LAST_IDX = (ADDR_W-2)'(DEPTH_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state, state_next;
  logic        ready_en;
  logic [2:0]  cnt;
  logic        is_load, err;
  logic [1:0]  off;
  logic [2:0]  f3;
  logic [31:0] word_q;
  logic [31:0] mem [DEPTH_WORDS];

  logic              accept, load_op, store_op;
  logic              oor, misal, illegal, req_err;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_al;
  logic [31:0]       shifted;
  logic [31:0]       ext;

  // Read has priority when both ops are asserted; the store is dropped.
  assign load_op  = mem_read;
  assign store_op = mem_write & ~mem_read;
  assign accept   = req_valid & req_ready & (mem_read | mem_write);

  assign word_idx = addr[ADDR_W-1:2];
  assign mem_idx  = addr[IDX_W+1:2];
  assign oor      = word_idx > LAST_IDX;
  assign misal    = ((funct3[1:0] == 2'b01) & addr[0]) |
                    ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign illegal  = load_op ? ((funct3 == 3'b011) | (funct3[2:1] == 2'b11))
                            : (funct3[2] | (funct3[1:0] == 2'b11));
  assign req_err  = oor | misal | illegal;

  always_comb begin
    be = 4'b1111;
    case (funct3[1:0])
      2'b00:   be = 4'b0001 << addr[1:0];
      2'b01:   be = 4'b0011 << addr[1:0];
      default: be = 4'b1111;
    endcase
  end

  assign wdata_al = wdata << {addr[1:0], 3'b000};

  // Store commits on the accept edge; the load word is captured on the same edge.
  always_ff @(posedge clk) begin
    if (accept & store_op & ~req_err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[mem_idx][8*b +: 8] <= wdata_al[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) word_q <= mem[mem_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      cnt      <= 3'd0;
      is_load  <= 1'b0;
      err      <= 1'b0;
      off      <= 2'b00;
      f3       <= 3'b000;
    end else begin
      state    <= state_next;
      ready_en <= 1'b1;
      if (accept) begin
        cnt     <= (load_op & ~req_err) ? 3'(READ_LAT) : 3'd1;
        is_load <= load_op;
        err     <= req_err;
        off     <= addr[1:0];
        f3      <= funct3;
      end else if (state == BUSY) begin
        cnt <= cnt - 3'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = ready_en;
        if (accept) state_next = BUSY;
      end
      BUSY: begin
        if (cnt == 3'd1) begin
          resp_valid = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign shifted = word_q >> {off, 3'b000};

  always_comb begin
    ext = shifted;
    case (f3)
      3'b000:  ext = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  ext = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  ext = {24'd0, shifted[7:0]};
      3'b101:  ext = {16'd0, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  assign resp_err = resp_valid & err;
  assign rdata    = (resp_valid & is_load & ~err) ? ext : 32'd0;

endmodule
`default_nettype wire
